// File: rtl/conv_window_scheduler_if.sv
// Bundle between the convolution window scheduler, the Macc datapath and the result consumer.
// Carries start/out_ready toward the scheduler and indices, Macc controls and window status away from it.
// The master modport is the scheduler side; the slave modport is the datapath/consumer side.
interface conv_window_scheduler_if #(
  parameter int AW = 2
);
  logic          start;
  logic          out_ready;
  logic [AW-1:0] frow;
  logic [AW-1:0] fcol;
  logic [AW-1:0] fdep;
  logic [AW-1:0] irow;
  logic [AW-1:0] icol;
  logic [AW-1:0] idep;
  logic          macc_en;
  logic          macc_clr;
  logic          out_valid;
  logic [AW-1:0] out_row;
  logic [AW-1:0] out_col;
  logic          busy;
  logic          done;

  modport master (
    input  start, out_ready,
    output frow, fcol, fdep, irow, icol, idep,
    output macc_en, macc_clr, out_valid, out_row, out_col, busy, done
  );

  modport slave (
    output start, out_ready,
    input  frow, fcol, fdep, irow, icol, idep,
    input  macc_en, macc_clr, out_valid, out_row, out_col, busy, done
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Sequences filter/image indices and Macc clear/enable for one stride-1 convolution pass.
// Latency: first tap one cycle after start; K*K*DEPTH taps + MACC_LAT drain cycles per window.
// Backpressure: a window result is held in EMIT, indices frozen, until out_ready is seen.
module conv_window_scheduler #(
  parameter int IMG_H    = 4,
  parameter int IMG_W    = 4,
  parameter int DEPTH    = 3,
  parameter int K        = 3,
  parameter int AW       = 2,
  parameter int MACC_LAT = 1
) (
  input logic clk,
  input logic rst,
  conv_window_scheduler_if.master bus
);
  localparam int OH = IMG_H - K + 1;
  localparam int OW = IMG_W - K + 1;
  localparam int DW = (MACC_LAT > 1) ? $clog2(MACC_LAT) : 1;

  localparam logic [AW-1:0] F_LAST  = AW'(K - 1);
  localparam logic [AW-1:0] D_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] R_LAST  = AW'(OH - 1);
  localparam logic [AW-1:0] C_LAST  = AW'(OW - 1);
  localparam logic [DW-1:0] DR_LAST = DW'((MACC_LAT > 0) ? MACC_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] frow_q, frow_d;
  logic [AW-1:0] fcol_q, fcol_d;
  logic [AW-1:0] fdep_q, fdep_d;
  logic [AW-1:0] orow_q, orow_d;
  logic [AW-1:0] ocol_q, ocol_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // State and counter registers; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frow_q  <= '0;
      fcol_q  <= '0;
      fdep_q  <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      frow_q  <= frow_d;
      fcol_q  <= fcol_d;
      fdep_q  <= fdep_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next state: depth innermost, then column, then row; windows in raster order.
  always_comb begin
    state_d = state_q;
    frow_d  = frow_q;
    fcol_d  = fcol_q;
    fdep_d  = fdep_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          frow_d  = '0;
          fcol_d  = '0;
          fdep_d  = '0;
          orow_d  = '0;
          ocol_d  = '0;
        end
      end
      RUN: begin
        if (fdep_q != D_LAST) begin
          fdep_d = fdep_q + 1'b1;
        end else if (fcol_q != F_LAST) begin
          fdep_d = '0;
          fcol_d = fcol_q + 1'b1;
        end else if (frow_q != F_LAST) begin
          fdep_d = '0;
          fcol_d = '0;
          frow_d = frow_q + 1'b1;
        end else begin
          // Last tap: indices stay on it while the product drains.
          dcnt_d  = '0;
          state_d = (MACC_LAT == 0) ? EMIT : DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt_q == DR_LAST) state_d = EMIT;
        else                   dcnt_d  = dcnt_q + 1'b1;
      end
      EMIT: begin
        if (bus.out_ready) begin
          frow_d = '0;
          fcol_d = '0;
          fdep_d = '0;
          if (orow_q == R_LAST && ocol_q == C_LAST) begin
            state_d = DONE;
            orow_d  = '0;
            ocol_d  = '0;
          end else if (ocol_q == C_LAST) begin
            state_d = RUN;
            ocol_d  = '0;
            orow_d  = orow_q + 1'b1;
          end else begin
            state_d = RUN;
            ocol_d  = ocol_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; start/out_ready never reach them combinationally.
  always_comb begin
    bus.frow      = frow_q;
    bus.fcol      = fcol_q;
    bus.fdep      = fdep_q;
    bus.irow      = orow_q + frow_q;
    bus.icol      = ocol_q + fcol_q;
    bus.idep      = fdep_q;
    bus.macc_en   = (state_q == RUN);
    bus.macc_clr  = (state_q == RUN) && (frow_q == '0) && (fcol_q == '0) && (fdep_q == '0);
    bus.out_valid = (state_q == EMIT);
    bus.out_row   = orow_q;
    bus.out_col   = ocol_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
  end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: cycle-by-cycle trace against a loop-built expected schedule,
// plus a single-window instance driving a behavioural Macc checked against a software dot product.
module tb_conv_window_scheduler;
  localparam int AW    = 2;
  localparam int OH_A  = 2;
  localparam int OW_A  = 2;
  localparam int K_A   = 3;
  localparam int D_A   = 3;
  localparam int LAT_A = 1;

  typedef struct packed {
    logic [AW-1:0] frow, fcol, fdep, irow, icol, idep;
    logic          en, clr, ov;
    logic [AW-1:0] orow, ocol;
    logic          busy, done;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_scheduler_if #(.AW(AW)) bus_a ();
  conv_window_scheduler_if #(.AW(AW)) bus_b ();

  conv_window_scheduler #(.IMG_H(4), .IMG_W(4), .DEPTH(3), .K(3), .AW(AW), .MACC_LAT(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  conv_window_scheduler #(.IMG_H(3), .IMG_W(3), .DEPTH(3), .K(3), .AW(AW), .MACC_LAT(2))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  bit   rdy_q[$];
  obs_t obs_log [0:400];

  // Behavioural Macc for the single-window instance: product stage, then accumulate.
  logic [7:0]  img  [0:2][0:2][0:2];
  logic [7:0]  filt [0:2][0:2][0:2];
  logic [15:0] prod_r, acc_r;
  logic        p_en, p_clr;
  always @(posedge clk) begin
    if (rst) begin
      p_en  <= 1'b0;
      p_clr <= 1'b0;
    end else begin
      p_en   <= bus_b.macc_en;
      p_clr  <= bus_b.macc_clr;
      prod_r <= 16'(img[bus_b.irow][bus_b.icol][bus_b.idep]) *
                16'(filt[bus_b.frow][bus_b.fcol][bus_b.fdep]);
      if (p_en) acc_r <= p_clr ? prod_r : acc_r + prod_r;
    end
  end

  function automatic obs_t sample_a();
    obs_t o;
    o.frow = bus_a.frow;  o.fcol = bus_a.fcol;  o.fdep = bus_a.fdep;
    o.irow = bus_a.irow;  o.icol = bus_a.icol;  o.idep = bus_a.idep;
    o.en   = bus_a.macc_en; o.clr = bus_a.macc_clr; o.ov = bus_a.out_valid;
    o.orow = bus_a.out_row; o.ocol = bus_a.out_col;
    o.busy = bus_a.busy;  o.done = bus_a.done;
    return o;
  endfunction

  // Indices only matter on valid taps, coordinates only while a window is presented.
  function automatic obs_t mask_obs(obs_t o, obs_t e);
    obs_t m = o;
    if (!e.en) begin
      m.frow = '0; m.fcol = '0; m.fdep = '0; m.irow = '0; m.icol = '0; m.idep = '0;
    end
    if (!e.ov) begin
      m.orow = '0; m.ocol = '0;
    end
    return m;
  endfunction

  // Expected schedule of one pass; st[w] is how many cycles out_ready is withheld at window w.
  task automatic build_a(input int st [4]);
    obs_t e;
    exp_q.delete();
    rdy_q.delete();
    for (int w = 0; w < OH_A * OW_A; w++) begin
      int orr = w / OW_A;
      int occ = w % OW_A;
      for (int fr = 0; fr < K_A; fr++)
        for (int fc = 0; fc < K_A; fc++)
          for (int fd = 0; fd < D_A; fd++) begin
            e = '0;
            e.frow = AW'(fr); e.fcol = AW'(fc); e.fdep = AW'(fd);
            e.irow = AW'(orr + fr); e.icol = AW'(occ + fc); e.idep = AW'(fd);
            e.en = 1'b1; e.clr = (fr == 0 && fc == 0 && fd == 0); e.busy = 1'b1;
            exp_q.push_back(e);
            rdy_q.push_back(1'($urandom_range(0, 1)));
          end
      for (int d = 0; d < LAT_A; d++) begin
        e = '0; e.busy = 1'b1;
        exp_q.push_back(e);
        rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      for (int s = 0; s <= st[w]; s++) begin
        e = '0; e.ov = 1'b1; e.orow = AW'(orr); e.ocol = AW'(occ); e.busy = 1'b1;
        exp_q.push_back(e);
        rdy_q.push_back(s == st[w]);
      end
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
    rdy_q.push_back(1'($urandom_range(0, 1)));
    e = '0;
    exp_q.push_back(e);
    rdy_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Launch with start in cycle 0, then compare every following cycle with the schedule.
  task automatic run_a(input string name, input int pa, input int pb,
                       output int done_cyc, output int ov_cnt);
    obs_t o;
    done_cyc = -1;
    ov_cnt   = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus_a.start     = ((i + 1 == pa || i + 1 == pb) && exp_q[i].busy) ? 1'b1 : 1'b0;
      bus_a.out_ready = rdy_q[i];
      o = sample_a();
      obs_log[i + 1] = o;
      if (o.done && done_cyc < 0) done_cyc = i + 1;
      if (o.ov) ov_cnt++;
      o = mask_obs(o, exp_q[i]);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h", name, i + 1, o, exp_q[i]);
      end
    end
    bus_a.start     = 1'b0;
    bus_a.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    o = sample_a();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", o);
    end
    n_cmp++;
    if ({bus_b.busy, bus_b.out_valid, bus_b.macc_en, bus_b.done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_state_b: got %b want 0000",
               {bus_b.busy, bus_b.out_valid, bus_b.macc_en, bus_b.done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_baseline();
    int st [4] = '{0, 0, 0, 0};
    int dc, ovc;
    build_a(st);
    run_a("baseline", -1, -1, dc, ovc);
    n_cmp++;
    if (dc !== 117) begin n_fail++; $display("FAIL baseline_done: got %0d want 117", dc); end
    n_cmp++;
    if (ovc !== 4) begin n_fail++; $display("FAIL baseline_windows: got %0d want 4", ovc); end
    // Window (0,1): first tap at cycle 30, tap (1,2,1) at 30 + 1*9 + 2*3 + 1.
    n_cmp++;
    if ({obs_log[30].irow, obs_log[30].icol, obs_log[30].clr} !== {2'd0, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL win01_first: got %h want %h",
               {obs_log[30].irow, obs_log[30].icol, obs_log[30].clr}, {2'd0, 2'd1, 1'b1});
    end
    n_cmp++;
    if ({obs_log[46].irow, obs_log[46].icol, obs_log[46].idep} !== {2'd1, 2'd3, 2'd1}) begin
      n_fail++;
      $display("FAIL win01_tap121: got %h want %h",
               {obs_log[46].irow, obs_log[46].icol, obs_log[46].idep}, {2'd1, 2'd3, 2'd1});
    end
  endtask

  task automatic test_backpressure();
    int st [4] = '{10, 0, 0, 0};
    int dc, ovc;
    build_a(st);
    run_a("backpressure", -1, -1, dc, ovc);
    n_cmp++;
    if (dc !== 127) begin n_fail++; $display("FAIL bp_done: got %0d want 127", dc); end
    for (int c = 30; c <= 39; c++) begin
      n_cmp++;
      if ({obs_log[c].frow, obs_log[c].fcol, obs_log[c].fdep} !==
          {obs_log[29].frow, obs_log[29].fcol, obs_log[29].fdep}) begin
        n_fail++;
        $display("FAIL bp_frozen cycle %0d: got %h want %h", c,
                 {obs_log[c].frow, obs_log[c].fcol, obs_log[c].fdep},
                 {obs_log[29].frow, obs_log[29].fcol, obs_log[29].fdep});
      end
    end
  endtask

  task automatic test_start_ignored();
    int st [4] = '{0, 0, 0, 0};
    int dc, ovc;
    build_a(st);
    run_a("start_ignored", 5, 60, dc, ovc);
    n_cmp++;
    if (dc !== 117) begin n_fail++; $display("FAIL start_ignored_done: got %0d want 117", dc); end
  endtask

  task automatic test_random_backpressure();
    int st [4];
    int sum = 0;
    int dc, ovc;
    for (int r = 0; r < 3; r++) begin
      sum = 0;
      for (int w = 0; w < 4; w++) begin
        st[w] = int'($urandom_range(0, 5));
        sum += st[w];
      end
      build_a(st);
      run_a("random_bp", int'($urandom_range(2, 100)), int'($urandom_range(2, 100)), dc, ovc);
      n_cmp++;
      if (dc !== 117 + sum) begin
        n_fail++;
        $display("FAIL random_bp_done: got %0d want %0d", dc, 117 + sum);
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t o;
    int st [4] = '{0, 0, 0, 0};
    int dc, ovc;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    o = sample_a();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %h want 0", o);
    end
    rst = 1'b0;
    @(negedge clk);
    build_a(st);
    run_a("after_reset", -1, -1, dc, ovc);
    n_cmp++;
    if (dc !== 117) begin n_fail++; $display("FAIL after_reset_done: got %0d want 117", dc); end
  endtask

  task automatic test_single_window();
    int dot = 0;
    int ov_cyc = -1;
    int dn_cyc = -1;
    logic [15:0] acc_seen = '0;
    logic [3:0]  coord = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int d = 0; d < 3; d++) begin
          img[r][c][d]  = 8'($urandom_range(0, 15));
          filt[r][c][d] = 8'($urandom_range(0, 15));
          dot += int'(img[r][c][d]) * int'(filt[r][c][d]);
        end
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      if (bus_b.out_valid && ov_cyc < 0) begin
        ov_cyc   = cyc;
        acc_seen = acc_r;
        coord    = {bus_b.out_row, bus_b.out_col};
      end
      if (bus_b.done && dn_cyc < 0) dn_cyc = cyc;
    end
    n_cmp++;
    if (ov_cyc !== 30) begin n_fail++; $display("FAIL single_valid_cycle: got %0d want 30", ov_cyc); end
    n_cmp++;
    if (dn_cyc !== 31) begin n_fail++; $display("FAIL single_done_cycle: got %0d want 31", dn_cyc); end
    n_cmp++;
    if (int'(acc_seen) !== dot) begin
      n_fail++;
      $display("FAIL single_dot: got %0d want %0d", acc_seen, dot);
    end
    n_cmp++;
    if (coord !== 4'b0) begin n_fail++; $display("FAIL single_coord: got %h want 0", coord); end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.start = 1'b0;
    bus_b.out_ready = 1'b1;
    test_reset();
    test_baseline();
    test_backpressure();
    test_start_ignored();
    test_random_backpressure();
    test_mid_reset();
    test_single_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
